// File: rtl/reg_writeback_pkg.sv
// Shared register-file widths and writeback defaults.
// Imported by reg_wb_fifo and reg_writeback.
package reg_writeback_pkg;

  localparam int REG_ID_W             = 5;
  localparam int REG_DATA_W           = 32;
  localparam int REG_ZERO_ID          = 0;
  localparam int REG_WB_DEFAULT_DEPTH = 4;

  // Occupancy counter width: must be able to hold DEPTH itself.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// In-order writeback FIFO: dual push (a older than b), single pop, occupancy
// count and per-entry id compare. Optional REG_WB_FORWARD_EN adds youngest-match data.
module reg_wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH  = REG_WB_DEFAULT_DEPTH,
  parameter int DATA_W = REG_DATA_W,
  parameter int ID_W   = REG_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_a,
  input  logic [ID_W-1:0]         push_a_id,
  input  logic [DATA_W-1:0]       push_a_data,
  input  logic                    push_b,
  input  logic [ID_W-1:0]         push_b_id,
  input  logic [DATA_W-1:0]       push_b_data,
  output logic                    pop,
  output logic [ID_W-1:0]         head_id,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [ID_W-1:0]         query_id,
`ifdef REG_WB_FORWARD_EN
  output logic [DATA_W-1:0]       fwd_data,
`endif
  output logic [DEPTH-1:0]        match_age
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = wb_cnt_w(DEPTH);

  logic [ID_W-1:0]   ids   [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_b, slot;

  assign pop       = (count != '0);
  assign head_id   = ids[rd_ptr];
  assign head_data = datas[rd_ptr];
  assign wr_ptr_b  = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: validity comes from rd_ptr/count alone.
  always_ff @(posedge clk) begin
    if (push_a) begin
      ids[wr_ptr]   <= push_a_id;
      datas[wr_ptr] <= push_a_data;
    end
    if (push_b) begin
      ids[wr_ptr_b]   <= push_b_id;
      datas[wr_ptr_b] <= push_b_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    match_age = '0;
    slot      = rd_ptr;
`ifdef REG_WB_FORWARD_EN
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ids[slot] == query_id)) begin
        match_age[k] = 1'b1;
`ifdef REG_WB_FORWARD_EN
        fwd_data = datas[slot];
`endif
      end
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write client: merges ALU and load results into an in-order FIFO
// and drives one registered write per clock. REG_WB_FORWARD_EN adds query data forwarding.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH  = REG_WB_DEFAULT_DEPTH,
  parameter int DATA_W = REG_DATA_W,
  parameter int ID_W   = REG_ID_W
) (
  input  logic                    reg_wb_clk,
  input  logic                    reg_wb_rst,
  input  logic                    reg_wb_alu_valid,
  output logic                    reg_wb_alu_ready,
  input  logic [ID_W-1:0]         reg_wb_alu_id,
  input  logic [DATA_W-1:0]       reg_wb_alu_data,
  input  logic                    reg_wb_mem_valid,
  output logic                    reg_wb_mem_ready,
  input  logic [ID_W-1:0]         reg_wb_mem_id,
  input  logic [DATA_W-1:0]       reg_wb_mem_data,
  output logic                    reg_wb_write_sig,
  output logic [ID_W-1:0]         reg_wb_write_id,
  output logic [DATA_W-1:0]       reg_wb_write_data,
  input  logic [ID_W-1:0]         reg_wb_query_id,
  output logic                    reg_wb_query_pending,
`ifdef REG_WB_FORWARD_EN
  output logic                    reg_wb_query_hit,
  output logic [DATA_W-1:0]       reg_wb_query_data,
`endif
  output logic [$clog2(DEPTH):0]  reg_wb_count
);

  localparam int CNT_W = wb_cnt_w(DEPTH);
  localparam logic [ID_W-1:0] ZERO_ID = ID_W'(REG_ZERO_ID);

  logic [CNT_W-1:0]  free_slots;
  logic              push_a, push_b, pop;
  logic [ID_W-1:0]   head_id;
  logic [DATA_W-1:0] head_data;
  logic [DEPTH-1:0]  match_age;
  logic              out_match, query_valid;
`ifdef REG_WB_FORWARD_EN
  logic [DATA_W-1:0] fifo_fwd_data;
`endif

  // Free space is taken from the pre-edge count, so a slot popped this edge is not reused.
  assign free_slots       = CNT_W'(DEPTH) - reg_wb_count;
  assign reg_wb_alu_ready = (free_slots >= CNT_W'(1));
  assign reg_wb_mem_ready = reg_wb_alu_valid ? (free_slots >= CNT_W'(2))
                                             : (free_slots >= CNT_W'(1));

  // Writes to register 0 are accepted but silently dropped.
  assign push_a = reg_wb_alu_valid && reg_wb_alu_ready && (reg_wb_alu_id != ZERO_ID);
  assign push_b = reg_wb_mem_valid && reg_wb_mem_ready && (reg_wb_mem_id != ZERO_ID);

  reg_wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_fifo (
    .clk         (reg_wb_clk),
    .rst         (reg_wb_rst),
    .push_a      (push_a),
    .push_a_id   (reg_wb_alu_id),
    .push_a_data (reg_wb_alu_data),
    .push_b      (push_b),
    .push_b_id   (reg_wb_mem_id),
    .push_b_data (reg_wb_mem_data),
    .pop         (pop),
    .head_id     (head_id),
    .head_data   (head_data),
    .count       (reg_wb_count),
    .query_id    (reg_wb_query_id),
`ifdef REG_WB_FORWARD_EN
    .fwd_data    (fifo_fwd_data),
`endif
    .match_age   (match_age)
  );

  always_ff @(posedge reg_wb_clk or posedge reg_wb_rst) begin
    if (reg_wb_rst) begin
      reg_wb_write_sig  <= 1'b0;
      reg_wb_write_id   <= '0;
      reg_wb_write_data <= '0;
    end else begin
      reg_wb_write_sig <= pop;
      if (pop) begin
        reg_wb_write_id   <= head_id;
        reg_wb_write_data <= head_data;
      end
    end
  end

  assign query_valid          = (reg_wb_query_id != ZERO_ID);
  assign out_match            = reg_wb_write_sig && (reg_wb_write_id == reg_wb_query_id);
  assign reg_wb_query_pending = query_valid && ((|match_age) || out_match);

`ifdef REG_WB_FORWARD_EN
  // Queued entries are younger than the write in flight, so they take priority.
  assign reg_wb_query_hit  = reg_wb_query_pending;
  assign reg_wb_query_data = !query_valid  ? '0 :
                             (|match_age)  ? fifo_fwd_data :
                             out_match     ? reg_wb_write_data : '0;
`endif

endmodule
